// File: rtl/id_ex_pkg.sv
// id_ex_pkg: shared widths and payload layout for the ID->EX pipeline stage.
//   Default field widths, a width helper, and the packed payload struct
//   (rd, rt, rs, func, rd1, rd2, paddr) built from the default widths.
package id_ex_pkg;

  localparam int unsigned REG_ADDR_W_DEF  = 3;
  localparam int unsigned FUNC_W_DEF      = 5;
  localparam int unsigned DATA_W_DEF      = 8;
  localparam int unsigned ADDR_W_DEF      = 12;
  localparam int unsigned STALL_CNT_W_DEF = 16;

  // Total bits carried from ID to EX for a given set of field widths.
  function automatic int unsigned payload_width(input int unsigned reg_addr_w,
                                                input int unsigned func_w,
                                                input int unsigned data_w,
                                                input int unsigned addr_w);
    return 3 * reg_addr_w + func_w + 2 * data_w + addr_w;
  endfunction

  localparam int unsigned PAYLOAD_W =
    payload_width(REG_ADDR_W_DEF, FUNC_W_DEF, DATA_W_DEF, ADDR_W_DEF);

  // Field order (MSB first) matches the packing used by id_ex_pipe_stage.
  typedef struct packed {
    logic [REG_ADDR_W_DEF-1:0] rd;
    logic [REG_ADDR_W_DEF-1:0] rt;
    logic [REG_ADDR_W_DEF-1:0] rs;
    logic [FUNC_W_DEF-1:0]     func;
    logic [DATA_W_DEF-1:0]     rd1;
    logic [DATA_W_DEF-1:0]     rd2;
    logic [ADDR_W_DEF-1:0]     paddr;
  } id_ex_payload_t;

endpackage

// File: rtl/id_ex_pipe_stage_skid.sv
// pipe_skid_buf: generic 2-entry skid buffer with valid/ready handshake.
//   clk, rst (async, active-low)
//   in_valid / in_ready / in_data   : upstream side; in_ready is a pure flop
//                                     output (skid entry empty)
//   flush                           : synchronous squash of everything held
//                                     and the word offered this cycle
//   out_valid / out_ready / out_data: downstream side, driven from main entry
//   occupancy                       : number of entries held (0..2)
module pipe_skid_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] main_data_q,  main_data_d;
  logic [WIDTH-1:0] skid_data_q,  skid_data_d;
  logic             accept;
  logic             emit;

  always_comb begin
    accept       = in_valid & ~skid_valid_q;
    emit         = main_valid_q & out_ready;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_data_d  = '0;
      skid_data_d  = '0;
    end else if (skid_valid_q) begin
      // Skid full implies main full; in_ready is low so nothing is accepted.
      if (emit) begin
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_q || emit) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
      end
    end else if (emit) begin
      main_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: rtl/id_ex_pipe_stage.sv
// id_ex_pipe_stage: ID->EX pipeline register with valid/ready handshake,
// 2-entry skid buffer, flush, and a saturating stall-cycle counter.
//   clk, rst (async, active-low)
//   in_valid/in_ready, rd_in/rt_in/rs_in, func_in, rd1_in/rd2_in, paddr_in
//   flush                 : squash held and incoming instructions
//   out_valid/out_ready, rd_out/rt_out/rs_out, func_out, rd1_out/rd2_out,
//   paddr_out             : registered payload to EX
//   occupancy             : entries held (0..2)
//   stall_cnt             : cycles with out_valid & ~out_ready, saturating;
//                           cleared only by reset
module id_ex_pipe_stage
  import id_ex_pkg::*;
#(
  parameter int unsigned REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int unsigned FUNC_W      = FUNC_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned STALL_CNT_W = STALL_CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [REG_ADDR_W-1:0]  rd_in,
  input  logic [REG_ADDR_W-1:0]  rt_in,
  input  logic [REG_ADDR_W-1:0]  rs_in,
  input  logic [FUNC_W-1:0]      func_in,
  input  logic [DATA_W-1:0]      rd1_in,
  input  logic [DATA_W-1:0]      rd2_in,
  input  logic [ADDR_W-1:0]      paddr_in,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [REG_ADDR_W-1:0]  rd_out,
  output logic [REG_ADDR_W-1:0]  rt_out,
  output logic [REG_ADDR_W-1:0]  rs_out,
  output logic [FUNC_W-1:0]      func_out,
  output logic [DATA_W-1:0]      rd1_out,
  output logic [DATA_W-1:0]      rd2_out,
  output logic [ADDR_W-1:0]      paddr_out,
  output logic [1:0]             occupancy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int unsigned PW = payload_width(REG_ADDR_W, FUNC_W, DATA_W, ADDR_W);

  logic [PW-1:0]          in_payload;
  logic [PW-1:0]          out_payload;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Same field order as id_ex_payload_t.
  assign in_payload = {rd_in, rt_in, rs_in, func_in, rd1_in, rd2_in, paddr_in};
  assign {rd_out, rt_out, rs_out, func_out, rd1_out, rd2_out, paddr_out} = out_payload;

  pipe_skid_buf #(
    .WIDTH(PW)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_payload),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_payload),
    .occupancy (occupancy)
  );

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Testbench for id_ex_pipe_stage: directed scenarios plus random traffic,
// checked against a queue-based reference model.
module tb_id_ex_pipe_stage;

  localparam int RA = 3;
  localparam int FW = 5;
  localparam int DW = 8;
  localparam int AW = 12;
  localparam int SW = 4;
  localparam int PW = 3 * RA + FW + 2 * DW + AW;
  localparam int unsigned STALL_MAX = (1 << SW) - 1;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [RA-1:0] rd_in, rt_in, rs_in;
  logic [FW-1:0] func_in;
  logic [DW-1:0] rd1_in, rd2_in;
  logic [AW-1:0] paddr_in;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [RA-1:0] rd_out, rt_out, rs_out;
  logic [FW-1:0] func_out;
  logic [DW-1:0] rd1_out, rd2_out;
  logic [AW-1:0] paddr_out;
  logic [1:0]    occupancy;
  logic [SW-1:0] stall_cnt;

  id_ex_pipe_stage #(
    .REG_ADDR_W  (RA),
    .FUNC_W      (FW),
    .DATA_W      (DW),
    .ADDR_W      (AW),
    .STALL_CNT_W (SW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rd_in     (rd_in),
    .rt_in     (rt_in),
    .rs_in     (rs_in),
    .func_in   (func_in),
    .rd1_in    (rd1_in),
    .rd2_in    (rd2_in),
    .paddr_in  (paddr_in),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rd_out    (rd_out),
    .rt_out    (rt_out),
    .rs_out    (rs_out),
    .func_out  (func_out),
    .rd1_out   (rd1_out),
    .rd2_out   (rd2_out),
    .paddr_out (paddr_out),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  string phase  = "init";

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: a FIFO of held words (at most two), a stall counter,
  // and a flag saying the payload outputs must read as zero.
  logic [PW-1:0] mq[$];
  int unsigned   m_stall;
  bit            m_clear;

  function automatic logic [PW-1:0] in_word();
    return {rd_in, rt_in, rs_in, func_in, rd1_in, rd2_in, paddr_in};
  endfunction

  function automatic logic [PW-1:0] out_word();
    return {rd_out, rt_out, rs_out, func_out, rd1_out, rd2_out, paddr_out};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_stall = 0;
    m_clear = 1'b1;
  endtask

  task automatic model_step();
    int  held  = mq.size();
    bit  emit  = (held > 0) && out_ready;
    bit  acc   = in_valid && (held < 2);
    if ((held > 0) && !out_ready && (m_stall < STALL_MAX)) m_stall++;
    if (flush) begin
      mq.delete();
      m_clear = 1'b1;
    end else begin
      if (emit) void'(mq.pop_front());
      if (acc) begin
        mq.push_back(in_word());
        m_clear = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    check({phase, "_out_valid"}, out_valid, mq.size() > 0);
    check({phase, "_in_ready"},  in_ready,  mq.size() < 2);
    check({phase, "_occupancy"}, occupancy, mq.size());
    check({phase, "_stall_cnt"}, stall_cnt, m_stall);
    if (mq.size() > 0)  check({phase, "_payload"}, out_word(), mq[0]);
    else if (m_clear)   check({phase, "_payload_zero"}, out_word(), '0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_step();
    #1;
    check_all();
  endtask

  task automatic set_in(input bit v, input logic [FW-1:0] f, input logic [DW-1:0] r1,
                        input logic [AW-1:0] pa);
    in_valid = v;
    func_in  = f;
    rd1_in   = r1;
    paddr_in = pa;
    rd_in    = RA'($urandom);
    rt_in    = RA'($urandom);
    rs_in    = RA'($urandom);
    rd2_in   = DW'($urandom);
  endtask

  task automatic set_rand();
    set_in(1'($urandom), FW'($urandom), DW'($urandom), AW'($urandom));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held low with random inputs.
    phase = "reset";
    rst = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    set_rand();
    model_reset();
    repeat (3) begin
      @(posedge clk);
      set_rand();
      out_ready = 1'($urandom);
      flush = 1'($urandom);
    end
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_occupancy", occupancy, 2'd0);
    check("reset_stall_cnt", stall_cnt, '0);
    check("reset_payload",   out_word(), '0);
    @(negedge clk);
    set_in(1'b0, '0, '0, '0);
    flush = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("reset_in_ready", in_ready, 1'b1);
    check_all();

    // Streaming four words back to back.
    phase = "stream";
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      set_in(1'b1, FW'(i), DW'(8'h11 * i), AW'($urandom));
      tick();
      check("stream_in_ready", in_ready, 1'b1);
      check("stream_func", func_out, FW'(i));
      check("stream_rd1", rd1_out, DW'(8'h11 * i));
    end
    set_in(1'b0, '0, '0, '0);
    tick();
    check("stream_drained", out_valid, 1'b0);

    // Backpressure: A then B with out_ready low for three cycles.
    phase = "backpressure";
    out_ready = 1'b0;
    set_in(1'b1, FW'($urandom), DW'($urandom), 12'hABC);
    tick();
    set_in(1'b1, FW'($urandom), DW'($urandom), 12'h123);
    tick();
    set_in(1'b0, '0, '0, '0);
    tick();
    tick();
    check("bp_occupancy", occupancy, 2'd2);
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_head", paddr_out, 12'hABC);
    check("bp_stall", stall_cnt, 4'd3);
    out_ready = 1'b1;
    tick();
    check("bp_second", paddr_out, 12'h123);
    check("bp_ready_back", in_ready, 1'b1);
    tick();
    check("bp_empty", out_valid, 1'b0);

    // Flush with two held and one offered.
    phase = "flush";
    out_ready = 1'b0;
    set_rand(); in_valid = 1'b1;
    tick();
    set_rand(); in_valid = 1'b1;
    tick();
    check("flush_pre_occ", occupancy, 2'd2);
    flush = 1'b1;
    set_in(1'b1, 5'h1F, DW'($urandom), AW'($urandom));
    tick();
    flush = 1'b0;
    set_in(1'b0, '0, '0, '0);
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_occ", occupancy, 2'd0);
    check("flush_payload", out_word(), '0);
    check("flush_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    repeat (3) tick();

    // Simultaneous accept and emit at occupancy 1.
    phase = "simul";
    out_ready = 1'b0;
    set_in(1'b1, 5'h0A, DW'($urandom), AW'($urandom));
    tick();
    out_ready = 1'b1;
    set_in(1'b1, 5'h15, 8'h5A, 12'h5A5);
    tick();
    check("simul_occ", occupancy, 2'd1);
    check("simul_func", func_out, 5'h15);
    check("simul_rd1", rd1_out, 8'h5A);
    set_in(1'b0, '0, '0, '0);
    tick();

    // Stall counter saturation, flush does not clear it.
    phase = "saturate";
    out_ready = 1'b0;
    set_rand(); in_valid = 1'b1;
    tick();
    set_in(1'b0, '0, '0, '0);
    repeat (20) tick();
    check("sat_value", stall_cnt, 4'hF);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("sat_after_flush", stall_cnt, 4'hF);

    // Asynchronous reset in the middle of a stall.
    phase = "async";
    set_rand(); in_valid = 1'b1;
    tick();
    set_in(1'b0, '0, '0, '0);
    tick();
    #2;
    rst = 1'b0;
    #1;
    check("async_stall", stall_cnt, '0);
    check("async_out_valid", out_valid, 1'b0);
    check("async_occ", occupancy, 2'd0);
    check("async_payload", out_word(), '0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all();

    // Random traffic against the model.
    phase = "random";
    for (int n = 0; n < 400; n++) begin
      set_rand();
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 23) == 0;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
